// File: rtl/par_pkg.sv
// par_pkg: shared RX state encoding, parity-type constants and parity helper
// Exports: rx_state_t, PAR_ODD, PAR_EVEN, parity_of()
package par_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARB, DONE} rx_state_t;
  localparam logic PAR_ODD = 1'b1;
  localparam logic PAR_EVEN = 1'b0;
  function automatic logic parity_of(input logic [15:0] d, input logic typ);
    return ^d ^ typ;
  endfunction
endpackage

// File: rtl/par_gen_chk_if.sv
// par_gen_chk_if: TX/RX parity bus between a driver (master) and par_gen_chk (slave)
// TX: PAR_EN, PAR_TYP, Data_Valid, P_DATA -> par_bit, par_bit_vld
// RX: frame_start, samp_valid, samp_bit, clr_cnt -> chk_done, par_err, err_cnt
interface par_gen_chk_if #(parameter int Data_Len = 8, parameter int ERR_CNT_W = 8);
  logic PAR_EN;
  logic PAR_TYP;
  logic Data_Valid;
  logic [Data_Len-1:0] P_DATA;
  logic par_bit;
  logic par_bit_vld;
  logic frame_start;
  logic samp_valid;
  logic samp_bit;
  logic clr_cnt;
  logic chk_done;
  logic par_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (
    output PAR_EN, PAR_TYP, Data_Valid, P_DATA, frame_start, samp_valid, samp_bit, clr_cnt,
    input par_bit, par_bit_vld, chk_done, par_err, err_cnt
  );
  modport slave (
    input PAR_EN, PAR_TYP, Data_Valid, P_DATA, frame_start, samp_valid, samp_bit, clr_cnt,
    output par_bit, par_bit_vld, chk_done, par_err, err_cnt
  );
endinterface

// File: rtl/par_rx_chk.sv
// par_rx_chk: RX parity checker FSM with saturating parity error counter
// In: CLK, RST (sync, active-low), par_en, par_typ, frame_start, samp_valid, samp_bit, clr_cnt
// Out: chk_done (strobe), par_err (held until next chk_done), err_cnt
module par_rx_chk
  import par_pkg::*;
#(
  parameter int Data_Len = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic par_en,
  input  logic par_typ,
  input  logic frame_start,
  input  logic samp_valid,
  input  logic samp_bit,
  input  logic clr_cnt,
  output logic chk_done,
  output logic par_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int CW = $clog2(Data_Len + 1);
  rx_state_t state;
  logic acc;
  logic en_l;
  logic typ_l;
  logic [CW-1:0] cnt;
  logic acc_nx;
  assign acc_nx = acc ^ samp_bit;
  // frame_start restarts from any state but DONE; in DONE it is ignored and
  // must still be present in the following IDLE cycle to take effect.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      acc <= 1'b0;
      cnt <= '0;
      en_l <= 1'b0;
      typ_l <= 1'b0;
      chk_done <= 1'b0;
      par_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      chk_done <= 1'b0;
      if (clr_cnt) err_cnt <= '0;
      else if (state == DONE && par_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      if (state != DONE && frame_start) begin
        state <= DATA;
        acc <= 1'b0;
        cnt <= '0;
        en_l <= par_en;
        typ_l <= par_typ;
      end else if (samp_valid && state == DATA) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(Data_Len - 1)) begin
          state <= en_l ? PARB : DONE;
          chk_done <= !en_l;
          par_err <= en_l ? par_err : 1'b0;
        end
      end else if (samp_valid && state == PARB) begin
        acc <= acc_nx;
        state <= DONE;
        chk_done <= 1'b1;
        par_err <= acc_nx != typ_l;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: rtl/par_gen_chk.sv
// par_gen_chk: parity generator (TX) and frame parity checker (RX)
// Ports: CLK, RST (sync, active-low), bus (par_gen_chk_if.slave: TX and RX signals)
module par_gen_chk
  import par_pkg::*;
#(
  parameter int Data_Len = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic CLK,
  input logic RST,
  par_gen_chk_if.slave bus
);
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bus.par_bit <= 1'b0;
      bus.par_bit_vld <= 1'b0;
    end else begin
      bus.par_bit_vld <= bus.Data_Valid && bus.PAR_EN;
      if (bus.Data_Valid) bus.par_bit <= bus.PAR_EN ? parity_of(16'(bus.P_DATA), bus.PAR_TYP) : 1'b0;
    end
  end
  par_rx_chk #(.Data_Len(Data_Len), .ERR_CNT_W(ERR_CNT_W)) u_rx (
    .CLK(CLK),
    .RST(RST),
    .par_en(bus.PAR_EN),
    .par_typ(bus.PAR_TYP),
    .frame_start(bus.frame_start),
    .samp_valid(bus.samp_valid),
    .samp_bit(bus.samp_bit),
    .clr_cnt(bus.clr_cnt),
    .chk_done(bus.chk_done),
    .par_err(bus.par_err),
    .err_cnt(bus.err_cnt)
  );
endmodule
